// File: rtl/changer_pkg.sv
// Shared types and defaults for the changer arbiter slice.
package changer_pkg;

  localparam int unsigned DefaultN = 8;

  typedef enum logic {S_EMPTY, S_FULL} slot_state_t;

endpackage

// File: rtl/changer.sv
// Bit-toggle datapath: y = a ^ (1 << b), with b a sign-magnitude index.
module changer #(
  parameter int unsigned N = changer_pkg::DefaultN
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] y_o,
  output logic         err_o
);

  localparam logic [N-1:0] NVal = N[N-1:0];
  localparam logic [N-1:0] One  = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] idx;

  always_comb begin
    idx   = {1'b0, b_i[N-2:0]};
    // Negative or out-of-range index is an error; the result is forced to zero.
    err_o = b_i[N-1] || (idx >= NVal);
    y_o   = err_o ? '0 : (a_i ^ (One << b_i[N-2:0]));
  end

endmodule

// File: rtl/changer_arb.sv
// Two-requester round-robin arbiter sharing one changer, with a one-entry
// registered output slot and a saturating error counter.
module changer_arb
  import changer_pkg::*;
#(
  parameter int unsigned N     = DefaultN,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_v0,
  output logic             o_rdy0,
  input  logic [N-1:0]     i_a0,
  input  logic [N-1:0]     i_b0,
  input  logic             i_v1,
  output logic             o_rdy1,
  input  logic [N-1:0]     i_a1,
  input  logic [N-1:0]     i_b1,
  output logic             o_v,
  input  logic             i_rdy,
  output logic [N-1:0]     o_out,
  output logic             o_ERR,
  output logic             o_id,
  output logic [CNT_W-1:0] o_err_cnt
);

  slot_state_t      state_q, state_d;
  logic [N-1:0]     out_q, out_d;
  logic             err_q, err_d;
  logic             id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prio_q, prio_d;

  logic             slot_free;
  logic             gnt0, gnt1, accept;
  logic [N-1:0]     mux_a, mux_b;
  logic [N-1:0]     res;
  logic             res_err;

  // A full slot being drained this cycle can take a new result without a bubble.
  always_comb begin
    slot_free = (state_q == S_EMPTY) || i_rdy;
    gnt0      = slot_free && i_v0 && (!i_v1 || !prio_q);
    gnt1      = slot_free && i_v1 && (!i_v0 || prio_q);
    accept    = gnt0 || gnt1;
    mux_a     = gnt1 ? i_a1 : i_a0;
    mux_b     = gnt1 ? i_b1 : i_b0;
  end

  changer #(
    .N (N)
  ) u_changer (
    .a_i   (mux_a),
    .b_i   (mux_b),
    .y_o   (res),
    .err_o (res_err)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    err_d   = err_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    if (accept) begin
      state_d = S_FULL;
      out_d   = res;
      err_d   = res_err;
      id_d    = gnt1;
      prio_d  = ~gnt1;
      if (res_err && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if ((state_q == S_FULL) && i_rdy) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_EMPTY;
      out_q   <= '0;
      err_q   <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
    end
  end

  assign o_rdy0    = gnt0;
  assign o_rdy1    = gnt1;
  assign o_v       = (state_q == S_FULL);
  assign o_out     = out_q;
  assign o_ERR     = err_q;
  assign o_id      = id_q;
  assign o_err_cnt = cnt_q;

endmodule

// File: tb/tb_changer_arb.sv
// Randomized and directed bench for changer_arb against a behavioural slot model.
module tb_changer_arb;

  localparam int unsigned N    = 8;
  localparam int unsigned CntW = 2;
  localparam int          CntMax = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            v0 = 1'b0, v1 = 1'b0, rdy = 1'b0;
  logic [N-1:0]    a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic            rdy0, rdy1, ov, oerr, oid;
  logic [N-1:0]    oout;
  logic [CntW-1:0] ocnt;

  int n_vec = 0;
  int n_err = 0;

  // Model of the visible slot state
  bit m_v, m_err, m_id, m_prio;
  int m_out, m_cnt;
  bit last_rdy0, last_rdy1;

  always #5 clk = ~clk;

  changer_arb #(
    .N     (N),
    .CNT_W (CntW)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_v0      (v0),
    .o_rdy0    (rdy0),
    .i_a0      (a0),
    .i_b0      (b0),
    .i_v1      (v1),
    .o_rdy1    (rdy1),
    .i_a1      (a1),
    .i_b1      (b1),
    .o_v       (ov),
    .i_rdy     (rdy),
    .o_out     (oout),
    .o_ERR     (oerr),
    .o_id      (oid),
    .o_err_cnt (ocnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_calc(input int a, input int b, output int y, output bit e);
    int mag;
    mag = b % (1 << (N - 1));
    e   = (b >= (1 << (N - 1))) || (mag >= N);
    y   = e ? 0 : ((a ^ (1 << mag)) % (1 << N));
  endfunction

  task automatic model_reset();
    m_v = 0; m_err = 0; m_id = 0; m_prio = 0; m_out = 0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".v"},   32'(ov),   32'(m_v));
    check({tag, ".out"}, 32'(oout), 32'(m_out));
    check({tag, ".err"}, 32'(oerr), 32'(m_err));
    check({tag, ".id"},  32'(oid),  32'(m_id));
    check({tag, ".cnt"}, 32'(ocnt), 32'(m_cnt));
  endtask

  // Called just after a rising edge: drive, check readies, clock, check slot.
  task automatic step(input bit sv0, input int sa0, input int sb0,
                      input bit sv1, input int sa1, input int sb1, input bit srdy);
    bit free, e0, e1, g, e;
    int y;
    v0 = sv0; a0 = N'(sa0); b0 = N'(sb0);
    v1 = sv1; a1 = N'(sa1); b1 = N'(sb1);
    rdy = srdy;
    #2;
    free = !m_v || srdy;
    e0 = free && sv0 && (!sv1 || !m_prio);
    e1 = free && sv1 && (!sv0 || m_prio);
    check("rdy0", 32'(rdy0), 32'(e0));
    check("rdy1", 32'(rdy1), 32'(e1));
    last_rdy0 = rdy0;
    last_rdy1 = rdy1;
    @(posedge clk);
    if (e0 || e1) begin
      g = e1;
      if (g) ref_calc(sa1, sb1, y, e);
      else   ref_calc(sa0, sb0, y, e);
      m_v = 1; m_out = y; m_err = e; m_id = g; m_prio = !g;
      if (e && m_cnt < CntMax) m_cnt++;
    end else if (m_v && srdy) begin
      m_v = 0;
    end
    #1;
    check_outputs("slot");
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("arst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v0 = 0; v1 = 0; rdy = 0;
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request
    step(1, 'h0F, 'h02, 0, 0, 0, 1);
    check("single.out", 32'(oout), 32'h0B);
    check("single.id", 32'(oid), 32'h0);

    // Error cases on requester 1
    step(0, 0, 0, 1, 'h55, 'h81, 1);
    check("neg.err", 32'(oerr), 32'h1);
    check("neg.cnt", 32'(ocnt), 32'h1);
    step(0, 0, 0, 1, 'h55, 'h08, 1);
    check("range.cnt", 32'(ocnt), 32'h2);
    step(0, 0, 0, 1, 'h00, 'h07, 1);
    check("msb.out", 32'(oout), 32'h80);
    check("msb.err", 32'(oerr), 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Reset while full with a non-zero count
    async_reset();

    // Contention alternates starting with requester 0
    for (int i = 0; i < 4; i++) begin
      step(1, i, 1, 1, i + 16, 2, 1);
      check("cont.id", 32'(oid), 32'(i % 2));
      check("cont.onehot", 32'(last_rdy0) + 32'(last_rdy1), 32'd1);
    end
    step(0, 0, 0, 0, 0, 0, 1);

    // Backpressure then drain-and-accept in the same cycle
    step(1, 'h11, 3, 1, 'h22, 4, 0);
    for (int i = 0; i < 3; i++) step(1, 'h33, 5, 1, 'h44, 6, 0);
    step(1, 'h33, 5, 1, 'h44, 6, 1);
    check("bp.v", 32'(ov), 32'h1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Counter saturation from zero
    async_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, i, 'h90, 0, 0, 0, 1);
      check("sat.cnt", 32'(ocnt), 32'((i + 1 > CntMax) ? CntMax : i + 1));
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int rb0, rb1;
      rb0 = ($urandom_range(0, 3) != 0) ? $urandom_range(0, N - 1) : $urandom_range(0, 255);
      rb1 = ($urandom_range(0, 3) != 0) ? $urandom_range(0, N - 1) : $urandom_range(0, 255);
      step($urandom_range(0, 1) == 1, $urandom_range(0, 255), rb0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 255), rb1,
           $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
